// File: rtl/sop_lut_eval_pkg.sv
// Shared types and constants for the serial-configured sum-of-products LUT evaluator.
package sop_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } sop_state_t;

   localparam logic [15:0] TT_INIT_DEF = 16'h55B5;

endpackage

// File: rtl/sop_lut_eval_if.sv
// Evaluation, configuration and sweep signals of the LUT evaluator.
interface sop_lut_eval_if #(parameter int N_IN = 4);

   logic            cfg_en;
   logic            cfg_bit;
   logic            in_valid;
   logic [N_IN-1:0] in_x;
   logic            f_s;
   logic            out_valid;
   logic            sweep_start;
   logic            sweep_busy;
   logic            sweep_done;
   logic [N_IN:0]   minterm_cnt;

   modport master (
      output cfg_en, cfg_bit, in_valid, in_x, sweep_start,
      input  f_s, out_valid, sweep_busy, sweep_done, minterm_cnt
   );

   modport slave (
      input  cfg_en, cfg_bit, in_valid, in_x, sweep_start,
      output f_s, out_valid, sweep_busy, sweep_done, minterm_cnt
   );

endinterface

// File: rtl/sop_lut_eval_sweep_ctr.sv
// Sweep index counter and minterm accumulator; idx is one bit wider than the
// address so the terminal count 2^N_IN is representable without wrapping.
module sop_sweep_ctr #(
   parameter int N_IN = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   en,
   input  logic [(1<<N_IN)-1:0]   tt,
   output logic [N_IN:0]          cnt,
   output logic                   last
);

   localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'((1 << N_IN) - 1);

   logic [N_IN:0] idx;
   logic          cur_bit;

   assign cur_bit = tt[idx[N_IN-1:0]];
   assign last    = (idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
         cnt <= '0;
      end else if (clr) begin
         idx <= '0;
         cnt <= '0;
      end else if (en) begin
         idx <= idx + 1'b1;
         cnt <= cnt + {{N_IN{1'b0}}, cur_bit};
      end
   end

endmodule

// File: rtl/sop_lut_eval.sv
// Truth-table LUT evaluator: serial table load, 1-cycle registered lookup,
// and a sweep that counts the minterms of the stored function.
module sop_lut_eval
   import sop_pkg::*;
#(
   parameter int                  N_IN    = 4,
   parameter logic [(1<<N_IN)-1:0] TT_INIT = TT_INIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   sop_lut_eval_if.slave     bus
);

   localparam int TT_W   = 1 << N_IN;
   localparam int STAGES = 1;

   sop_state_t        state_q, state_d;
   logic [TT_W-1:0]   tt;
   logic [STAGES:0]   vld_pipe;
   logic              f_q;
   logic              eval;
   logic              tt_shift;
   logic              sweep_clr;
   logic              sweep_en;
   logic              sweep_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // sweep_start wins over cfg_en so the table cannot move under a new sweep
   always_comb begin
      state_d   = state_q;
      eval      = 1'b0;
      tt_shift  = 1'b0;
      sweep_clr = 1'b0;
      sweep_en  = 1'b0;
      case (state_q)
         IDLE: begin
            eval = bus.in_valid;
            if (bus.sweep_start) begin
               sweep_clr = 1'b1;
               state_d   = SWEEP;
            end else begin
               tt_shift  = bus.cfg_en;
            end
         end
         SWEEP: begin
            sweep_en = 1'b1;
            if (sweep_last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           tt <= TT_INIT;
      else if (tt_shift) tt <= {tt[TT_W-2:0], bus.cfg_bit};
   end

   // lookup reads the pre-shift table when eval and shift share a cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       f_q <= 1'b0;
      else if (eval) f_q <= tt[bus.in_x];
   end

   assign vld_pipe[0] = eval;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_pipe[STAGES:1] <= '0;
      else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

   sop_sweep_ctr #(.N_IN(N_IN)) u_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (sweep_clr),
      .en   (sweep_en),
      .tt   (tt),
      .cnt  (bus.minterm_cnt),
      .last (sweep_last)
   );

   assign bus.f_s        = f_q;
   assign bus.out_valid  = vld_pipe[STAGES];
   assign bus.sweep_busy = (state_q == SWEEP);
   assign bus.sweep_done = (state_q == DONE);

endmodule

// File: tb/tb_sop_lut_eval.sv
// Directed bench for sop_lut_eval: lookup, serial load, sweep, reset, N_IN=3.
module tb_sop_lut_eval;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   sop_lut_eval_if #(.N_IN(4)) bus4 ();
   sop_lut_eval_if #(.N_IN(3)) bus3 ();

   sop_lut_eval #(.N_IN(4), .TT_INIT(16'h55B5)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   sop_lut_eval #(.N_IN(3), .TT_INIT(8'hA5)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic shift_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) begin
         bus4.cfg_en  = 1'b1;
         bus4.cfg_bit = w[i];
         tick();
      end
      bus4.cfg_en  = 1'b0;
      bus4.cfg_bit = 1'b0;
   endtask

   task automatic eval4(input int x, input logic exp, input string tag);
      bus4.in_valid = 1'b1;
      bus4.in_x     = 4'(x);
      tick();
      bus4.in_valid = 1'b0;
      check(tag, 32'(bus4.f_s), 32'(exp));
      check({tag, "_vld"}, 32'(bus4.out_valid), 32'd1);
   endtask

   task automatic sweep4(output int n);
      bus4.sweep_start = 1'b1;
      tick();
      bus4.sweep_start = 1'b0;
      n = 0;
      while (bus4.sweep_busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      logic [15:0] ref_tt;
      int n;
      errors = 0;
      checks = 0;
      ref_tt = 16'h55B5;
      rst = 1'b1;
      bus4.cfg_en = 0; bus4.cfg_bit = 0; bus4.in_valid = 0; bus4.in_x = '0; bus4.sweep_start = 0;
      bus3.cfg_en = 0; bus3.cfg_bit = 0; bus3.in_valid = 0; bus3.in_x = '0; bus3.sweep_start = 0;
      #2;
      check("rst_f_s",  32'(bus4.f_s), 32'd0);
      check("rst_vld",  32'(bus4.out_valid), 32'd0);
      check("rst_busy", 32'(bus4.sweep_busy), 32'd0);
      check("rst_done", 32'(bus4.sweep_done), 32'd0);
      check("rst_cnt",  32'(bus4.minterm_cnt), 32'd0);
      tick();
      rst = 1'b0;

      // back-to-back lookups of the reset table
      for (int k = 0; k < 16; k++) begin
         bus4.in_valid = 1'b1;
         bus4.in_x     = 4'(k);
         tick();
         check($sformatf("lut_x%0d", k), 32'(bus4.f_s), 32'(ref_tt[k]));
         check($sformatf("lut_vld%0d", k), 32'(bus4.out_valid), 32'd1);
      end
      bus4.in_valid = 1'b0;
      tick();
      check("idle_vld", 32'(bus4.out_valid), 32'd0);
      check("idle_hold", 32'(bus4.f_s), 32'd0);

      // sweep of reset table
      sweep4(n);
      check("sweep_len", 32'(n), 32'd16);
      check("sweep_done", 32'(bus4.sweep_done), 32'd1);
      check("sweep_cnt", 32'(bus4.minterm_cnt), 32'd9);
      tick();
      check("done_pulse", 32'(bus4.sweep_done), 32'd0);
      check("cnt_hold", 32'(bus4.minterm_cnt), 32'd9);

      // all-ones table: count must not wrap
      shift_word(16'hFFFF);
      sweep4(n);
      check("ff_len", 32'(n), 32'd16);
      check("ff_cnt", 32'(bus4.minterm_cnt), 32'd16);
      tick();

      // single-minterm table, then lookup coincident with a shift
      shift_word(16'h0001);
      eval4(0, 1'b1, "one_x0");
      eval4(15, 1'b0, "one_x15");
      bus4.in_valid = 1'b1; bus4.in_x = 4'd0; bus4.cfg_en = 1'b1; bus4.cfg_bit = 1'b0;
      tick();
      bus4.in_valid = 1'b0; bus4.cfg_en = 1'b0;
      check("coinc_old", 32'(bus4.f_s), 32'd1);
      eval4(0, 1'b0, "coinc_new0");
      eval4(1, 1'b1, "coinc_new1");

      // restore, then try to disturb a sweep with cfg_en and sweep_start
      rst = 1'b1; #1; rst = 1'b0;
      bus4.sweep_start = 1'b1; bus4.cfg_en = 1'b1; bus4.cfg_bit = 1'b0;
      tick();
      bus4.sweep_start = 1'b0; bus4.cfg_en = 1'b0;
      n = 0;
      while (bus4.sweep_busy && n < 40) begin
         n++;
         bus4.sweep_start = (n == 3);
         bus4.cfg_en      = (n == 3) || (n == 5);
         tick();
      end
      bus4.cfg_en = 1'b0;
      check("dist_len", 32'(n), 32'd16);
      check("dist_cnt", 32'(bus4.minterm_cnt), 32'd9);
      bus4.sweep_start = 1'b1;
      tick();
      bus4.sweep_start = 1'b0;
      check("done_ign_start", 32'(bus4.sweep_busy), 32'd0);
      check("dist_cnt_hold", 32'(bus4.minterm_cnt), 32'd9);
      eval4(0, 1'b1, "dist_x0");
      eval4(1, 1'b0, "dist_x1");
      eval4(7, 1'b1, "dist_x7");

      // async reset in the middle of a sweep
      bus4.sweep_start = 1'b1;
      tick();
      bus4.sweep_start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("mid_busy", 32'(bus4.sweep_busy), 32'd1);
      #3 rst = 1'b1;
      #1;
      check("arst_f_s",  32'(bus4.f_s), 32'd0);
      check("arst_busy", 32'(bus4.sweep_busy), 32'd0);
      check("arst_done", 32'(bus4.sweep_done), 32'd0);
      check("arst_cnt",  32'(bus4.minterm_cnt), 32'd0);
      check("arst_vld",  32'(bus4.out_valid), 32'd0);
      #1 rst = 1'b0;
      sweep4(n);
      check("post_rst_len", 32'(n), 32'd16);
      check("post_rst_cnt", 32'(bus4.minterm_cnt), 32'd9);
      tick();

      // three-input instance
      bus3.sweep_start = 1'b1;
      tick();
      bus3.sweep_start = 1'b0;
      n = 0;
      while (bus3.sweep_busy && n < 40) begin
         n++;
         tick();
      end
      check("n3_len", 32'(n), 32'd8);
      check("n3_done", 32'(bus3.sweep_done), 32'd1);
      check("n3_cnt", 32'(bus3.minterm_cnt), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sop_lut_eval.md
SOP_LUT_EVAL -- requirements
Module: sop_lut_eval

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of function inputs (2..8).
REQ-002 SHALL have parameter TT_INIT, default 16'h55B5 (width 2^N_IN), reset truth table; bit k = f at input index k.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_en  input  1  shift one truth-table bit in this cycle.
REQ-006 SHALL have port cfg_bit  input  1  serial truth-table data.
REQ-007 SHALL have port in_valid  input  1  evaluate in_x this cycle.
REQ-008 SHALL have port in_x  input  N_IN  input vector; MSB = first literal (a), LSB = last (d).
REQ-009 SHALL have port f_s  output  1  registered function value.
REQ-010 SHALL have port out_valid  output  1  f_s valid this cycle.
REQ-011 SHALL have port sweep_start  input  1  start minterm-count sweep.
REQ-012 SHALL have port sweep_busy  output  1  sweep in progress.
REQ-013 SHALL have port sweep_done  output  1  one-cycle pulse, sweep complete.
REQ-014 SHALL have port minterm_cnt  output  N_IN+1  number of 1-bits in truth table from last sweep.

Function
REQ-015 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-016 SHALL, in IDLE with cfg_en=1, shift tt <= {tt[2^N_IN-2:0], cfg_bit}; first bit shifted ends at MSB after 2^N_IN shifts.
REQ-017 SHALL ignore cfg_en in SWEEP and DONE (truth table frozen).
REQ-018 SHALL, in IDLE with in_valid=1, register f_s <= tt[in_x] and out_valid <= 1 on the next edge (latency 1 cycle).
REQ-019 SHALL use the truth table as it was before any same-cycle cfg_en shift when in_valid and cfg_en coincide.
REQ-020 SHALL hold f_s and drive out_valid=0 in cycles following in_valid=0, and ignore in_valid outside IDLE.
REQ-021 SHALL, on sweep_start=1 in IDLE, clear minterm_cnt and index counter to 0 and enter SWEEP; sweep_start overrides cfg_en in the same cycle (no shift).
REQ-022 SHALL, in SWEEP, add tt[idx] to minterm_cnt and increment idx each cycle for exactly 2^N_IN cycles, then enter DONE.
REQ-023 SHALL assert sweep_busy throughout SWEEP only; SHALL pulse sweep_done for the single DONE cycle, then return to IDLE.
REQ-024 SHALL hold minterm_cnt stable from DONE until the next accepted sweep_start.
REQ-025 SHALL ignore sweep_start in SWEEP and DONE.
REQ-026 SHALL size idx to N_IN+1 bits so terminal count 2^N_IN does not wrap; all-ones table yields minterm_cnt = 2^N_IN.

Reset
REQ-027 SHALL, on rst=1 at any time (including mid-sweep), immediately load tt=TT_INIT, state=IDLE, idx=0, minterm_cnt=0, f_s=0, out_valid=0, sweep_busy=0, sweep_done=0.
REQ-028 SHALL accept cfg_en, in_valid and sweep_start on the first edge after rst deasserts.

Structure
REQ-029 SHALL place the FSM state enum and default TT_INIT constant in shared package sop_pkg.
REQ-030 SHALL implement the sweep index counter and minterm accumulator as one sub-module sop_sweep_ctr (parameter N_IN).
REQ-031 SHALL keep all state in clk-domain flops; no latches, no combinational path from inputs to outputs.

Verification
REQ-032 SHALL cover: after reset, in_valid with in_x=0,1,...,15 consecutively -> f_s matches 16'h55B5 bitwise one cycle later (1,0,1,0,1,1,0,1,1,0,1,0,1,0,1,0), out_valid=1 each.
REQ-033 SHALL cover: reset, sweep_start -> sweep_busy high 16 cycles, sweep_done pulse, minterm_cnt=9.
REQ-034 SHALL cover: 16 cfg_en shifts of bits of 16'hFFFF then sweep -> minterm_cnt=16 (no wrap); load 16'h0001, in_valid in_x=0 -> f_s=1, in_x=15 -> f_s=0.
REQ-035 SHALL cover: cfg_en and sweep_start pulsed during SWEEP -> truth table unchanged, sweep length still 16, result unchanged.
REQ-036 SHALL cover: rst asserted at sweep cycle 7 -> all outputs 0 asynchronously, tt=16'h55B5; next sweep gives minterm_cnt=9.
REQ-037 SHALL cover: N_IN=3, TT_INIT=8'hA5 -> sweep takes 8 cycles, minterm_cnt=4.
